// File: rtl/mul_hilo_ctrl_if.sv
// Handshake between the HI/LO controller and an external multi-cycle multiplier.
// The controller drives operands and a held start; the multiplier answers with a product and ready.
interface mul_hilo_ctrl_if;
    logic        mul_signed_o;
    logic [31:0] mul_a_o;
    logic [31:0] mul_b_o;
    logic        mul_start_o;
    logic [63:0] mul_result_i;
    logic        mul_ready_i;

    modport master (
        output mul_signed_o, mul_a_o, mul_b_o, mul_start_o,
        input  mul_result_i, mul_ready_i
    );

    modport slave (
        input  mul_signed_o, mul_a_o, mul_b_o, mul_start_o,
        output mul_result_i, mul_ready_i
    );
endinterface

// File: rtl/mul_hilo_ctrl.sv
// HI/LO register file and multiplier sequencer for the EX stage (IDLE/BUSY/DRAIN/DONE).
// Optional macro HILO_BYPASS_EN forwards a same-cycle HI/LO write straight to hi_o/lo_o.
module mul_hilo_ctrl #(
    parameter logic [31:0] HILO_RST_VAL = 32'h0000_0000
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   ex_valid_i,
    input  logic [2:0]             op_i,
    input  logic [31:0]            rs_i,
    input  logic [31:0]            rt_i,
    input  logic                   flush_i,
    mul_hilo_ctrl_if.master        mul,
    output logic                   stall_o,
    output logic [31:0]            hi_o,
    output logic [31:0]            lo_o
);

    localparam logic [2:0] OP_MULT  = 3'b001;
    localparam logic [2:0] OP_MULTU = 3'b010;
    localparam logic [2:0] OP_MTHI  = 3'b011;
    localparam logic [2:0] OP_MTLO  = 3'b100;
    localparam logic [2:0] OP_MFHI  = 3'b101;
    localparam logic [2:0] OP_MFLO  = 3'b110;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t      state;
    state_t      state_next;

    logic        live;
    logic        is_mul_op;
    logic        is_hilo_op;
    logic        accept;

    logic [31:0] hi_q;
    logic [31:0] lo_q;
    logic        hi_we;
    logic        lo_we;
    logic [31:0] hi_nx;
    logic [31:0] lo_nx;
    logic        stall;

    assign live       = ex_valid_i && !flush_i;
    assign is_mul_op  = (op_i == OP_MULT) || (op_i == OP_MULTU);
    assign is_hilo_op = (op_i inside {OP_MULT, OP_MULTU, OP_MTHI, OP_MTLO, OP_MFHI, OP_MFLO});
    assign accept     = (state == IDLE) && live && is_mul_op;

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state: a flush in BUSY always beats a coincident ready
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_next = BUSY;
                end
            end
            BUSY: begin
                if (flush_i) begin
                    state_next = mul.mul_ready_i ? DONE : DRAIN;
                end else if (mul.mul_ready_i) begin
                    state_next = DONE;
                end
            end
            DRAIN: begin
                if (mul.mul_ready_i) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Outputs and HI/LO write enables; everything is forced quiet while reset is low
    always_comb begin
        stall = 1'b0;
        hi_we = 1'b0;
        lo_we = 1'b0;
        hi_nx = hi_q;
        lo_nx = lo_q;
        if (rst) begin
            case (state)
                IDLE: begin
                    stall = accept;
                    if (live && (op_i == OP_MTHI)) begin
                        hi_we = 1'b1;
                        hi_nx = rs_i;
                    end
                    if (live && (op_i == OP_MTLO)) begin
                        lo_we = 1'b1;
                        lo_nx = rs_i;
                    end
                end
                BUSY: begin
                    stall = 1'b1;
                    if (mul.mul_ready_i && !flush_i) begin
                        hi_we = 1'b1;
                        lo_we = 1'b1;
                        hi_nx = mul.mul_result_i[63:32];
                        lo_nx = mul.mul_result_i[31:0];
                    end
                end
                DRAIN: begin
                    // The orphaned product is still in flight; hold back anything touching HI/LO
                    stall = ex_valid_i && is_hilo_op;
                end
                DONE: begin
                    stall = 1'b0;
                end
                default: begin
                    stall = 1'b0;
                end
            endcase
        end
    end

    assign stall_o = stall;

    // Multiplier request: start stays up for as long as a product is outstanding
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mul.mul_start_o  <= 1'b0;
            mul.mul_signed_o <= 1'b0;
            mul.mul_a_o      <= 32'h0000_0000;
            mul.mul_b_o      <= 32'h0000_0000;
        end else begin
            mul.mul_start_o <= (state_next == BUSY) || (state_next == DRAIN);
            if (accept) begin
                mul.mul_signed_o <= (op_i == OP_MULT);
                mul.mul_a_o      <= rs_i;
                mul.mul_b_o      <= rt_i;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hi_q <= HILO_RST_VAL;
            lo_q <= HILO_RST_VAL;
        end else begin
            if (hi_we) begin
                hi_q <= hi_nx;
            end
            if (lo_we) begin
                lo_q <= lo_nx;
            end
        end
    end

`ifdef HILO_BYPASS_EN
    assign hi_o = hi_we ? hi_nx : hi_q;
    assign lo_o = lo_we ? lo_nx : lo_q;
`else
    assign hi_o = hi_q;
    assign lo_o = lo_q;
`endif

endmodule

// File: tb/tb_mul_hilo_ctrl.sv
// Directed bench for mul_hilo_ctrl with a fixed-latency multiplier stub.
// HI/LO updates are scored by a monitor against a queue filled by the stimulus.
module tb_mul_hilo_ctrl;
    localparam int LAT = 5;

    localparam logic [2:0] OP_NONE  = 3'b000;
    localparam logic [2:0] OP_MULT  = 3'b001;
    localparam logic [2:0] OP_MULTU = 3'b010;
    localparam logic [2:0] OP_MTHI  = 3'b011;
    localparam logic [2:0] OP_MTLO  = 3'b100;
    localparam logic [2:0] OP_MFHI  = 3'b101;
    localparam logic [2:0] OP_MFLO  = 3'b110;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        ex_valid = 1'b0;
    logic [2:0]  op = 3'b000;
    logic [31:0] rs = 32'h0;
    logic [31:0] rt = 32'h0;
    logic        flush = 1'b0;
    logic        stall;
    logic [31:0] hi;
    logic [31:0] lo;

    int   checks = 0;
    int   errors = 0;
    exp_t q[$];

    mul_hilo_ctrl_if mif();

    mul_hilo_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .ex_valid_i (ex_valid),
        .op_i       (op),
        .rs_i       (rs),
        .rt_i       (rt),
        .flush_i    (flush),
        .mul        (mif),
        .stall_o    (stall),
        .hi_o       (hi),
        .lo_o       (lo)
    );

    always #5 clk = ~clk;

    // Multiplier stub: ready pulses in the LAT+1-th cycle that start is high
    int mcnt;
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            mcnt             <= 0;
            mif.mul_ready_i  <= 1'b0;
            mif.mul_result_i <= 64'h0;
        end else begin
            mif.mul_ready_i <= 1'b0;
            if (mif.mul_start_o && !mif.mul_ready_i) begin
                if (mcnt == LAT - 1) begin
                    mif.mul_ready_i  <= 1'b1;
                    mif.mul_result_i <= mif.mul_signed_o
                        ? ({{32{mif.mul_a_o[31]}}, mif.mul_a_o} * {{32{mif.mul_b_o[31]}}, mif.mul_b_o})
                        : ({32'h0, mif.mul_a_o} * {32'h0, mif.mul_b_o});
                    mcnt <= 0;
                end else begin
                    mcnt <= mcnt + 1;
                end
            end else begin
                mcnt <= 0;
            end
        end
    end

    // Monitor: every change of {hi,lo} must match the next queued expectation
    bit          mon_en = 1'b0;
    bit          have_prev = 1'b0;
    logic [63:0] prev;
    logic [63:0] cur;
    exp_t        mon_e;
    always @(negedge clk) begin
        if (mon_en) begin
            cur = {hi, lo};
            if (have_prev && (cur !== prev)) begin
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL hilo_unexpected_write actual=%h required=%h", cur, prev);
                end else begin
                    mon_e = q.pop_front();
                    if (cur !== {mon_e.hi, mon_e.lo}) begin
                        errors++;
                        $display("FAIL hilo_write actual=%h required=%h", cur, {mon_e.hi, mon_e.lo});
                    end
                end
            end
            prev      = cur;
            have_prev = 1'b1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic push(input logic [31:0] h, input logic [31:0] l);
        exp_t e;
        e.hi = h;
        e.lo = l;
        q.push_back(e);
    endtask

    // Issue one multiply; called at posedge+1. from_done: presented while the previous one sits in DONE.
    task automatic do_mul(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                          input logic sgn, input logic [31:0] ehi, input logic [31:0] elo,
                          input bit from_done, input bit last);
        bit done;
        push(ehi, elo);
        ex_valid = 1'b1;
        op       = o;
        rs       = a;
        rt       = b;
        if (from_done) begin
            #1;
            chk("done_ignores_op_stall", stall, 0);
            chk("done_ignores_op_start", mif.mul_start_o, 0);
            tick();
        end
        @(negedge clk);
        chk("accept_stall", stall, 1);
        chk("accept_start_low", mif.mul_start_o, 0);
        tick();
        done = 1'b0;
        for (int n = 0; n < 20 && !done; n++) begin
            @(negedge clk);
            chk("busy_stall", stall, 1);
            if (n == 0) begin
                chk("busy_start", mif.mul_start_o, 1);
                chk("busy_signed", mif.mul_signed_o, sgn);
                chk("busy_a", mif.mul_a_o, a);
                chk("busy_b", mif.mul_b_o, b);
            end
            done = mif.mul_ready_i;
            tick();
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL mul_ready_timeout actual=0 required=1");
        end
        @(negedge clk);
        chk("done_stall", stall, 0);
        chk("done_start", mif.mul_start_o, 0);
        if (last) begin
            ex_valid = 1'b0;
            op       = OP_NONE;
            tick();
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        bit done;
        #3;
        chk("rst_hi", hi, 0);
        chk("rst_lo", lo, 0);
        chk("rst_start", mif.mul_start_o, 0);
        chk("rst_signed", mif.mul_signed_o, 0);
        chk("rst_a", mif.mul_a_o, 0);
        chk("rst_b", mif.mul_b_o, 0);
        ex_valid = 1'b1;
        op       = OP_MULT;
        #1;
        chk("rst_stall", stall, 0);
        ex_valid = 1'b0;
        op       = OP_NONE;
        mon_en   = 1'b1;
        tick();
        rst = 1'b1;

        // Signed and unsigned multiplies
        do_mul(OP_MULT,  32'hFFFF_FFFE, 32'h0000_0003, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 1'b0, 1'b1);
        do_mul(OP_MULTU, 32'hFFFF_FFFF, 32'h0000_0002, 1'b0, 32'h0000_0001, 32'hFFFF_FFFE, 1'b0, 1'b1);

        // MTHI/MFHI, MTLO/MFLO, and flushed HI/LO ops
        push(32'h1234_5678, 32'hFFFF_FFFE);
        ex_valid = 1'b1;
        op       = OP_MTHI;
        rs       = 32'h1234_5678;
        @(negedge clk);
        chk("mthi_stall", stall, 0);
`ifdef HILO_BYPASS_EN
        chk("mthi_bypass_hi", hi, 32'h1234_5678);
`endif
        tick();
        op = OP_MFHI;
        @(negedge clk);
        chk("mfhi_hi", hi, 32'h1234_5678);
        chk("mfhi_stall", stall, 0);
        tick();
        push(32'h1234_5678, 32'hA5A5_A5A5);
        op = OP_MTLO;
        rs = 32'hA5A5_A5A5;
        @(negedge clk);
        chk("mtlo_stall", stall, 0);
        tick();
        op = OP_MFLO;
        @(negedge clk);
        chk("mflo_lo", lo, 32'hA5A5_A5A5);
        tick();
        op    = OP_MTHI;
        rs    = 32'hFFFF_0000;
        flush = 1'b1;
        @(negedge clk);
        chk("flushed_mthi_stall", stall, 0);
        tick();
        op = OP_MULT;
        @(negedge clk);
        chk("flushed_mult_stall", stall, 0);
        tick();
        flush    = 1'b0;
        ex_valid = 1'b0;
        op       = OP_NONE;
        @(negedge clk);
        chk("flushed_hi_kept", hi, 32'h1234_5678);
        chk("flushed_mult_no_start", mif.mul_start_o, 0);
        tick();

        // Flush in the third BUSY cycle, then drain the orphaned product
        ex_valid = 1'b1;
        op       = OP_MULT;
        rs       = 32'h0000_0003;
        rt       = 32'h0000_0005;
        @(negedge clk);
        chk("flush_accept_stall", stall, 1);
        tick();
        tick();
        tick();
        flush = 1'b1;
        @(negedge clk);
        chk("flush_busy_stall", stall, 1);
        tick();
        flush    = 1'b0;
        ex_valid = 1'b0;
        op       = OP_NONE;
        @(negedge clk);
        chk("drain_none_stall", stall, 0);
        chk("drain_start", mif.mul_start_o, 1);
        tick();
        ex_valid = 1'b1;
        op       = OP_MTLO;
        rs       = 32'hDEAD_BEEF;
        done     = 1'b0;
        for (int n = 0; n < 20 && !done; n++) begin
            @(negedge clk);
            chk("drain_mtlo_stall", stall, 1);
            done = mif.mul_ready_i;
            tick();
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL drain_ready_timeout actual=0 required=1");
        end
        ex_valid = 1'b0;
        op       = OP_NONE;
        @(negedge clk);
        chk("drain_done_stall", stall, 0);
        chk("drain_done_start", mif.mul_start_o, 0);
        chk("drain_hi_kept", hi, 32'h1234_5678);
        chk("drain_lo_kept", lo, 32'hA5A5_A5A5);
        tick();
        @(negedge clk);
        chk("drain_idle_lo_kept", lo, 32'hA5A5_A5A5);
        tick();

        // Back-to-back: second multiply waits in EX through DONE
        do_mul(OP_MULT,  32'h0000_0007, 32'h0000_0006, 1'b1, 32'h0000_0000, 32'h0000_002A, 1'b0, 1'b0);
        do_mul(OP_MULTU, 32'h0001_0000, 32'h0001_0000, 1'b0, 32'h0000_0001, 32'h0000_0000, 1'b1, 1'b1);

        // Asynchronous reset in the middle of BUSY
        ex_valid = 1'b1;
        op       = OP_MULT;
        rs       = 32'h0000_0100;
        rt       = 32'h0000_0100;
        @(negedge clk);
        chk("rstmid_accept_stall", stall, 1);
        tick();
        tick();
        @(negedge clk);
        chk("rstmid_busy_start", mif.mul_start_o, 1);
        #2;
        push(32'h0000_0000, 32'h0000_0000);
        rst = 1'b0;
        #1;
        chk("rstmid_start", mif.mul_start_o, 0);
        chk("rstmid_stall", stall, 0);
        chk("rstmid_hi", hi, 0);
        chk("rstmid_lo", lo, 0);
        chk("rstmid_a", mif.mul_a_o, 0);
        ex_valid = 1'b0;
        op       = OP_NONE;
        tick();
        tick();
        rst = 1'b1;
        do_mul(OP_MULTU, 32'h0000_0002, 32'h0000_0003, 1'b0, 32'h0000_0000, 32'h0000_0006, 1'b0, 1'b1);

        tick();
        tick();
        tick();
        chk("scoreboard_empty", q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mul_hilo_ctrl.md
MUL_HILO_CTRL -- requirements
Module: mul_hilo_ctrl

Interface
REQ-001 The block SHALL have parameter HILO_RST_VAL, default 32'h0000_0000, giving the reset value of HI and LO.
REQ-002 The block SHALL have the following ports:
- clk  in  1  single clock; all state changes on its rising edge.
- rst  in  1  reset, asynchronous and active-low.
- ex_valid_i  in  1  an instruction is present in EX.
- op_i  in  3  operation: 000 none, 001 MULT, 010 MULTU, 011 MTHI, 100 MTLO, 101 MFHI, 110 MFLO, 111 reserved (treated as none).
- rs_i  in  32  multiplicand / MTHI / MTLO source.
- rt_i  in  32  multiplier.
- flush_i  in  1  cancels the EX instruction.
- mul_signed_o  out  1  signed request to the multiplier (1 for MULT).
- mul_a_o  out  32  multiplicand to the multiplier.
- mul_b_o  out  32  multiplier operand to the multiplier.
- mul_start_o  out  1  start request, held high until the result is taken.
- mul_result_i  in  64  multiplier product.
- mul_ready_i  in  1  multiplier result is valid.
- stall_o  out  1  freezes EX and all earlier stages.
- hi_o  out  32  HI register read value.
- lo_o  out  32  LO register read value.

Function
REQ-003 The block SHALL implement four states: IDLE, BUSY, DRAIN and DONE.
REQ-004 IDLE behaviour SHALL be:
- Condition: ex_valid_i=1, flush_i=0, op MULT or MULTU.
- Action: latch rs_i/rt_i into mul_a_o/mul_b_o, latch mul_signed_o, drive mul_start_o=1 from the next cycle, go to BUSY.
- stall_o: combinationally 1 in that cycle.
REQ-005 In BUSY, mul_start_o, mul_a_o, mul_b_o and mul_signed_o SHALL be held stable.
REQ-006 In BUSY, stall_o SHALL be 1 in every cycle, including the cycle in which mul_ready_i=1.
REQ-007 In BUSY with mul_ready_i=1, the block SHALL write HI<=mul_result_i[63:32] and LO<=mul_result_i[31:0] on that edge, then go to DONE.
REQ-008 In BUSY with flush_i=1 and mul_ready_i=0, the block SHALL go to DRAIN.
REQ-009 In BUSY with flush_i=1 and mul_ready_i=1 in the same cycle, the flush SHALL win: no HI/LO write, go to DONE.
REQ-010 DRAIN behaviour SHALL be:
- mul_start_o: held at 1.
- stall_o: 1 only when ex_valid_i=1 and op_i is any HI/LO op (001-110), otherwise 0.
- mul_ready_i=1: discard the result (no HI/LO write), go to DONE.
REQ-011 DONE behaviour SHALL be:
- mul_start_o: 0 (frees the multiplier).
- stall_o: 0.
- op_i: ignored, so the retiring MULT is not reissued.
- Next state: IDLE unconditionally.
REQ-012 MTHI/MTLO in IDLE with ex_valid_i=1 and flush_i=0 SHALL write HI or LO from rs_i on the clock edge, with no stall.
REQ-013 MFHI/MFLO SHALL need no action in the block; hi_o/lo_o are read directly.
REQ-014 Any HI/LO op with flush_i=1 SHALL have no effect.
REQ-015 Latency from MULT acceptance to the HI/LO update SHALL be the multiplier latency plus 1 cycle.
REQ-016 stall_o SHALL release exactly 1 cycle after the HI/LO update.
REQ-017 mul_start_o SHALL be a registered output, and mul_start_o SHALL be 0 in IDLE.

Reset
REQ-018 rst=0 SHALL asynchronously force the following, independent of clk:
- state: IDLE.
- HI, LO: HILO_RST_VAL.
- mul_start_o, mul_signed_o, stall_o: 0.
- mul_a_o, mul_b_o: 0.
REQ-019 Reset asserted during BUSY or DRAIN SHALL abandon the operation with no HI/LO write; the multiplier is reset by the same system reset.
REQ-020 After rst deasserts, the first rising edge SHALL be able to accept a MULT.

Configuration
REQ-021 Macro HILO_BYPASS_EN SHALL select hi_o/lo_o bypassing:
- Defined: in any cycle where HI/LO is written (MTHI/MTLO, or the BUSY completion), hi_o/lo_o SHALL combinationally present the new value in that same cycle.
- Undefined: hi_o/lo_o SHALL be the registered HI/LO only, with the new value visible the cycle after the write.

Verification
REQ-022 The bench SHALL cover these directed scenarios:
- MULT rs=32'hFFFF_FFFE (-2), rt=32'h0000_0003 -> HI=32'hFFFF_FFFF, LO=32'hFFFF_FFFA; stall_o high from acceptance through the ready cycle, low in DONE.
- MULTU rs=32'hFFFF_FFFF, rt=32'h0000_0002 -> HI=32'h0000_0001, LO=32'hFFFF_FFFE; mul_signed_o=0.
- MTHI rs=32'h1234_5678 then MFHI next cycle -> hi_o=32'h1234_5678, no stall; with HILO_BYPASS_EN, hi_o=32'h1234_5678 already in the MTHI cycle.
- MULT accepted, flush_i pulsed in the 3rd BUSY cycle -> DRAIN, stall_o=0 for op none, stall_o=1 if a MTLO is presented, HI/LO unchanged after ready, mul_start_o=0 in DONE.
- Back-to-back MULT, MULT (second held in EX through DONE) -> second accepted only in the IDLE cycle after DONE; each result written exactly once.
- rst=0 mid-BUSY -> immediate IDLE, HI=LO=HILO_RST_VAL, mul_start_o=0 before the next clk edge.
